// File: rtl/urv_muldiv.sv
`default_nettype none
// ============================================================================
//  Module   : urv_muldiv
//  Purpose  : Iterative RV32M multiply/divide unit for the uRV execute stage.
//             Accepts decoded operands in X, holds the pipeline through
//             x_stall_req_o while it iterates, and presents the final result
//             on x_rd_o with x_done_o high until the pipeline takes it.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    XLEN        operand/result width (even, >= 8)
//    STEP_BITS   multiplier/quotient bits retired per cycle (1, 2 or 4)
//  Ports
//    clk_i          clock
//    rst_i          asynchronous active-high reset
//    x_stall_i      pipeline stall from any source
//    x_kill_i       kill of the instruction in X
//    d_valid_i      instruction in X is valid
//    d_is_muldiv_i  instruction is an M-extension op
//    d_fun_i        M-extension function code (funct3)
//    d_rs1_i        operand 1 (multiplicand / dividend)
//    d_rs2_i        operand 2 (multiplier / divisor)
//    x_stall_req_o  stall request to pipeline control
//    x_done_o       x_rd_o holds the final result
//    x_rd_o         result
// ============================================================================
module urv_muldiv #(
  parameter int XLEN      = 32,
  parameter int STEP_BITS = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            x_stall_i,
  input  logic            x_kill_i,
  input  logic            d_valid_i,
  input  logic            d_is_muldiv_i,
  input  logic [2:0]      d_fun_i,
  input  logic [XLEN-1:0] d_rs1_i,
  input  logic [XLEN-1:0] d_rs2_i,
  output logic            x_stall_req_o,
  output logic            x_done_o,
  output logic [XLEN-1:0] x_rd_o
);

  localparam int N     = XLEN / STEP_BITS;
  localparam int CNT_W = $clog2(N + 1);

  localparam logic [2:0] FN_MUL    = 3'b000;
  localparam logic [2:0] FN_MULH   = 3'b001;
  localparam logic [2:0] FN_MULHSU = 3'b010;
  localparam logic [2:0] FN_MULHU  = 3'b011;
  localparam logic [2:0] FN_DIV    = 3'b100;
  localparam logic [2:0] FN_DIVU   = 3'b101;
  localparam logic [2:0] FN_REM    = 3'b110;
  localparam logic [2:0] FN_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q,   cnt_d;
  logic [2:0]          fun_q,   fun_d;
  logic                neg_q,   neg_d;    // negate the selected result in FIX
  logic [2*XLEN:0]     acc_q,   acc_d;    // product, or remainder:quotient
  logic [XLEN-1:0]     b_q,     b_d;      // multiplier / divisor magnitude
  logic [XLEN-1:0]     rd_q,    rd_d;
  logic                done_q,  done_d;

  // --------------------------------------------------------------------------
  // Operand decode for the start cycle
  // --------------------------------------------------------------------------
  logic            start;
  logic            rs1_signed, rs2_signed;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] special_res;
  logic            start_neg;

  assign start = d_valid_i & d_is_muldiv_i & ~x_kill_i & (state_q == S_IDLE);

  assign rs1_signed = (d_fun_i == FN_MULH) | (d_fun_i == FN_MULHSU) |
                      (d_fun_i == FN_DIV)  | (d_fun_i == FN_REM);
  assign rs2_signed = (d_fun_i == FN_MULH) | (d_fun_i == FN_DIV) |
                      (d_fun_i == FN_REM);

  assign a_neg = rs1_signed & d_rs1_i[XLEN-1];
  assign b_neg = rs2_signed & d_rs2_i[XLEN-1];
  assign a_mag = a_neg ? -d_rs1_i : d_rs1_i;
  assign b_mag = b_neg ? -d_rs2_i : d_rs2_i;

  // Remainder takes the dividend's sign; every other signed result takes the
  // XOR of both operand signs (b_neg is already 0 for an unsigned rs2).
  assign start_neg = (d_fun_i == FN_REM) ? a_neg : (a_neg ^ b_neg);

  assign div_zero = d_fun_i[2] & (d_rs2_i == '0);
  assign div_ovf  = ((d_fun_i == FN_DIV) | (d_fun_i == FN_REM)) &
                    (d_rs1_i == {1'b1, {(XLEN-1){1'b0}}}) & (&d_rs2_i);

  // Quotient paths (fun[1]==0) give all-ones on /0 and rs1 on overflow;
  // remainder paths give rs1 on /0 and 0 on overflow.
  always_comb begin
    special_res = '0;
    if (div_zero) begin
      special_res = d_fun_i[1] ? d_rs1_i : '1;
    end else begin
      special_res = d_fun_i[1] ? '0 : d_rs1_i;
    end
  end

  // --------------------------------------------------------------------------
  // Unrolled iteration: STEP_BITS shift-add / restoring steps per cycle
  // --------------------------------------------------------------------------
  logic [2*XLEN:0] mul_acc, div_acc, div_sh;
  logic [XLEN:0]   mul_sum;
  logic [XLEN+1:0] div_diff;

  always_comb begin
    mul_acc  = acc_q;
    div_acc  = acc_q;
    mul_sum  = '0;
    div_sh   = '0;
    div_diff = '0;
    for (int s = 0; s < STEP_BITS; s++) begin
      // Multiplier sits in the low half and is consumed LSB first; the
      // partial product grows in the upper XLEN+1 bits and shifts right.
      mul_sum = mul_acc[2*XLEN:XLEN] + (mul_acc[0] ? {1'b0, b_q} : '0);
      mul_acc = {1'b0, mul_sum, mul_acc[XLEN-1:1]};
      // Restoring divide: shift dividend bit into the remainder, subtract
      // the divisor and keep the difference only when it did not borrow.
      div_sh   = {div_acc[2*XLEN-1:0], 1'b0};
      div_diff = {1'b0, div_sh[2*XLEN:XLEN]} - {2'b00, b_q};
      if (!div_diff[XLEN+1]) begin
        div_acc = {div_diff[XLEN:0], div_sh[XLEN-1:1], 1'b1};
      end else begin
        div_acc = div_sh;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Sign fix-up and result selection
  // --------------------------------------------------------------------------
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;
  logic [XLEN-1:0]   fix_res;

  assign prod     = acc_q[2*XLEN-1:0];
  assign prod_fix = neg_q ? -prod : prod;
  assign quo_fix  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign rem_fix  = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

  always_comb begin
    fix_res = '0;
    case (fun_q)
      FN_MUL:                        fix_res = prod_fix[XLEN-1:0];
      FN_MULH, FN_MULHSU, FN_MULHU:  fix_res = prod_fix[2*XLEN-1:XLEN];
      FN_DIV, FN_DIVU:               fix_res = quo_fix;
      FN_REM, FN_REMU:               fix_res = rem_fix;
      default:                       fix_res = '0;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      fun_q   <= '0;
      neg_q   <= 1'b0;
      acc_q   <= '0;
      b_q     <= '0;
      rd_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fun_q   <= fun_d;
      neg_q   <= neg_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      rd_q    <= rd_d;
      done_q  <= done_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and datapath updates
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fun_d   = fun_q;
    neg_d   = neg_q;
    acc_d   = acc_q;
    b_d     = b_q;
    rd_d    = rd_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          fun_d = d_fun_i;
          neg_d = start_neg;
          b_d   = b_mag;
          acc_d = {{(XLEN+1){1'b0}}, a_mag};
          if (div_zero || div_ovf) begin
            rd_d    = special_res;
            state_d = S_DONE;
          end else begin
            cnt_d   = CNT_W'(N);
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        acc_d = fun_q[2] ? div_acc : mul_acc;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        rd_d    = fix_res;
        state_d = S_DONE;
      end
      S_DONE: begin
        // The result is consumed on the first unstalled cycle; while stalled
        // the same instruction stays on d_* and must not be restarted.
        if (!x_stall_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A kill abandons the operation and leaves the last result untouched.
    if (x_kill_i && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      rd_d    = rd_q;
    end
  end

  assign done_d = (state_d == S_DONE);

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign x_stall_req_o = ~rst_i & ~x_kill_i &
                         (start | (state_q == S_BUSY) | (state_q == S_FIX));
  assign x_done_o      = done_q;
  assign x_rd_o        = rd_q;

endmodule
`default_nettype wire

// File: tb/tb_urv_muldiv.sv
`default_nettype none
// ============================================================================
//  Module   : tb_urv_muldiv
//  Purpose  : Directed self-checking bench for urv_muldiv. Two instances run
//             side by side, one retiring 1 bit per cycle and one retiring 4.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_urv_muldiv;

  localparam logic [2:0] FN_MUL    = 3'b000;
  localparam logic [2:0] FN_MULH   = 3'b001;
  localparam logic [2:0] FN_MULHSU = 3'b010;
  localparam logic [2:0] FN_MULHU  = 3'b011;
  localparam logic [2:0] FN_DIV    = 3'b100;
  localparam logic [2:0] FN_DIVU   = 3'b101;
  localparam logic [2:0] FN_REM    = 3'b110;
  localparam logic [2:0] FN_REMU   = 3'b111;

  localparam int NS1 = 34;   // stall cycles, 1 bit/cycle
  localparam int NS4 = 10;   // stall cycles, 4 bits/cycle

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, kill, ismd;
  logic        v1, v4;
  logic [2:0]  fun;
  logic [31:0] rs1, rs2;
  logic        sreq1, sreq4, done1, done4;
  logic [31:0] rd1, rd4;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  urv_muldiv #(.XLEN(32), .STEP_BITS(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .x_stall_i(stall), .x_kill_i(kill),
    .d_valid_i(v1), .d_is_muldiv_i(ismd), .d_fun_i(fun),
    .d_rs1_i(rs1), .d_rs2_i(rs2),
    .x_stall_req_o(sreq1), .x_done_o(done1), .x_rd_o(rd1)
  );

  urv_muldiv #(.XLEN(32), .STEP_BITS(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .x_stall_i(stall), .x_kill_i(kill),
    .d_valid_i(v4), .d_is_muldiv_i(ismd), .d_fun_i(fun),
    .d_rs1_i(rs1), .d_rs2_i(rs2),
    .x_stall_req_o(sreq4), .x_done_o(done4), .x_rd_o(rd4)
  );

  // Issue one op to both instances starting at the current cycle and report
  // what each produced: result, stall cycles counted, cycle index of x_done_o.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r1, output logic [31:0] r4,
                        output int s1, output int s4, output int d1, output int d4);
    fun = f; rs1 = a; rs2 = b; v1 = 1'b1; v4 = 1'b1;
    r1 = 'x; r4 = 'x; s1 = 0; s4 = 0; d1 = -1; d4 = -1;
    for (int c = 0; c < 80; c++) begin
      #1;
      if (sreq1) s1++;
      if (sreq4) s4++;
      if (d1 < 0 && done1) begin d1 = c; r1 = rd1; v1 = 1'b0; end
      if (d4 < 0 && done4) begin d4 = c; r4 = rd4; v4 = 1'b0; end
      if (d1 >= 0 && d4 >= 0) break;
      @(negedge clk);
    end
    v1 = 1'b0; v4 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; kill = 1'b0; ismd = 1'b1;
    fun = FN_MUL; rs1 = 32'd3; rs2 = 32'd4; v1 = 1'b1; v4 = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    nvec++;
    if (sreq1 !== 1'b0 || sreq4 !== 1'b0) begin
      nmis++; $display("FAIL reset_stall_req: got %b/%b expected 0/0", sreq1, sreq4);
    end
    nvec++;
    if (done1 !== 1'b0 || done4 !== 1'b0) begin
      nmis++; $display("FAIL reset_done: got %b/%b expected 0/0", done1, done4);
    end
    nvec++;
    if (rd1 !== 32'h0 || rd4 !== 32'h0) begin
      nmis++; $display("FAIL reset_rd: got %h/%h expected 0/0", rd1, rd4);
    end
    @(negedge clk);
    v1 = 1'b0; v4 = 1'b0; rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mul();
    logic [2:0]  fv [6] = '{FN_MUL, FN_MULH, FN_MULHU, FN_MULHSU, FN_MUL, FN_MULHU};
    logic [31:0] av [6] = '{32'd7, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00010000, 32'h80000000};
    logic [31:0] bv [6] = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00010000, 32'd2};
    logic [31:0] ev [6] = '{32'hFFFFFFEB, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    logic [31:0] r1, r4;
    int s1, s4, d1, d4;
    for (int i = 0; i < 6; i++) begin
      run_op(fv[i], av[i], bv[i], r1, r4, s1, s4, d1, d4);
      nvec++;
      if (r1 !== ev[i]) begin
        nmis++; $display("FAIL mul[%0d] step1 rd: got %h expected %h", i, r1, ev[i]);
      end
      nvec++;
      if (r4 !== ev[i]) begin
        nmis++; $display("FAIL mul[%0d] step4 rd: got %h expected %h", i, r4, ev[i]);
      end
      nvec++;
      if (s1 !== NS1 || d1 !== NS1) begin
        nmis++; $display("FAIL mul[%0d] step1 timing: stall %0d done@%0d expected %0d/%0d", i, s1, d1, NS1, NS1);
      end
      nvec++;
      if (s4 !== NS4 || d4 !== NS4) begin
        nmis++; $display("FAIL mul[%0d] step4 timing: stall %0d done@%0d expected %0d/%0d", i, s4, d4, NS4, NS4);
      end
    end
  endtask

  task automatic test_div();
    logic [2:0]  fv [7] = '{FN_DIV, FN_REM, FN_DIVU, FN_REMU, FN_DIV, FN_REM, FN_DIV};
    logic [31:0] av [7] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'd7, 32'd7, 32'h80000000};
    logic [31:0] bv [7] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'd2};
    logic [31:0] ev [7] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFFD, 32'd1, 32'hC0000000};
    logic [31:0] r1, r4;
    int s1, s4, d1, d4;
    for (int i = 0; i < 7; i++) begin
      run_op(fv[i], av[i], bv[i], r1, r4, s1, s4, d1, d4);
      nvec++;
      if (r1 !== ev[i]) begin
        nmis++; $display("FAIL div[%0d] step1 rd: got %h expected %h", i, r1, ev[i]);
      end
      nvec++;
      if (r4 !== ev[i]) begin
        nmis++; $display("FAIL div[%0d] step4 rd: got %h expected %h", i, r4, ev[i]);
      end
      nvec++;
      if (s1 !== NS1 || d1 !== NS1) begin
        nmis++; $display("FAIL div[%0d] step1 timing: stall %0d done@%0d expected %0d/%0d", i, s1, d1, NS1, NS1);
      end
      nvec++;
      if (s4 !== NS4 || d4 !== NS4) begin
        nmis++; $display("FAIL div[%0d] step4 timing: stall %0d done@%0d expected %0d/%0d", i, s4, d4, NS4, NS4);
      end
    end
  endtask

  task automatic test_special();
    logic [2:0]  fv [4] = '{FN_DIVU, FN_REM, FN_DIV, FN_REM};
    logic [31:0] av [4] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000};
    logic [31:0] bv [4] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] ev [4] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};
    logic [31:0] r1, r4;
    int s1, s4, d1, d4;
    for (int i = 0; i < 4; i++) begin
      run_op(fv[i], av[i], bv[i], r1, r4, s1, s4, d1, d4);
      nvec++;
      if (r1 !== ev[i] || r4 !== ev[i]) begin
        nmis++; $display("FAIL special[%0d] rd: got %h/%h expected %h", i, r1, r4, ev[i]);
      end
      nvec++;
      if (s1 !== 1 || d1 !== 1 || s4 !== 1 || d4 !== 1) begin
        nmis++; $display("FAIL special[%0d] timing: stall %0d/%0d done@%0d/%0d expected 1", i, s1, s4, d1, d4);
      end
    end
  endtask

  task automatic test_kill();
    logic [31:0] r1, r4;
    int s1, s4, d1, d4;
    fun = FN_DIV; rs1 = 32'd100; rs2 = 32'd7; v1 = 1'b1; v4 = 1'b1;
    repeat (10) @(negedge clk);
    kill = 1'b1;
    #1;
    nvec++;
    if (sreq1 !== 1'b0 || sreq4 !== 1'b0) begin
      nmis++; $display("FAIL kill_stall_req: got %b/%b expected 0/0", sreq1, sreq4);
    end
    @(negedge clk);
    kill = 1'b0; v1 = 1'b0; v4 = 1'b0;
    #1;
    nvec++;
    if (done1 !== 1'b0 || done4 !== 1'b0 || sreq1 !== 1'b0 || sreq4 !== 1'b0) begin
      nmis++; $display("FAIL kill_idle: done %b/%b stall %b/%b expected all 0", done1, done4, sreq1, sreq4);
    end
    run_op(FN_MUL, 32'd3, 32'd4, r1, r4, s1, s4, d1, d4);
    nvec++;
    if (r1 !== 32'd12 || r4 !== 32'd12) begin
      nmis++; $display("FAIL kill_restart rd: got %h/%h expected 0000000c", r1, r4);
    end
    nvec++;
    if (d1 !== NS1 || d4 !== NS4) begin
      nmis++; $display("FAIL kill_restart timing: done@%0d/%0d expected %0d/%0d", d1, d4, NS1, NS4);
    end
  endtask

  task automatic test_ext_stall();
    int waited;
    stall = 1'b1;
    fun = FN_MUL; rs1 = 32'd6; rs2 = 32'd7; v1 = 1'b1; v4 = 1'b1;
    waited = 0;
    #1;
    while (!done1 && waited < 60) begin
      @(negedge clk); #1; waited++;
    end
    nvec++;
    if (waited !== NS1) begin
      nmis++; $display("FAIL ext_stall latency: done after %0d cycles expected %0d", waited, NS1);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      nvec++;
      if (done1 !== 1'b1 || done4 !== 1'b1 || rd1 !== 32'd42 || rd4 !== 32'd42 ||
          sreq1 !== 1'b0 || sreq4 !== 1'b0) begin
        nmis++; $display("FAIL ext_stall_hold[%0d]: done %b/%b rd %h/%h stall %b/%b expected 1/1 2a/2a 0/0",
                         k, done1, done4, rd1, rd4, sreq1, sreq4);
      end
    end
    @(negedge clk);
    stall = 1'b0; v1 = 1'b0; v4 = 1'b0;
    #1;
    nvec++;
    if (done1 !== 1'b1 || done4 !== 1'b1) begin
      nmis++; $display("FAIL ext_stall_release_cycle: done %b/%b expected 1/1", done1, done4);
    end
    @(negedge clk); #1;
    nvec++;
    if (done1 !== 1'b0 || done4 !== 1'b0 || rd1 !== 32'd42 || rd4 !== 32'd42) begin
      nmis++; $display("FAIL ext_stall_idle: done %b/%b rd %h/%h expected 0/0 2a/2a", done1, done4, rd1, rd4);
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    logic [31:0] r1, r4;
    int s1, s4, d1, d4;
    fun = FN_DIV; rs1 = 32'd100; rs2 = 32'd7; v1 = 1'b1; v4 = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    nvec++;
    if (rd1 !== 32'h0 || rd4 !== 32'h0 || done1 !== 1'b0 || done4 !== 1'b0 ||
        sreq1 !== 1'b0 || sreq4 !== 1'b0) begin
      nmis++; $display("FAIL async_reset: rd %h/%h done %b/%b stall %b/%b expected all 0",
                       rd1, rd4, done1, done4, sreq1, sreq4);
    end
    @(negedge clk);
    rst = 1'b0; v1 = 1'b0; v4 = 1'b0;
    @(negedge clk);
    run_op(FN_DIVU, 32'd100, 32'd7, r1, r4, s1, s4, d1, d4);
    nvec++;
    if (r1 !== 32'd14 || r4 !== 32'd14 || d1 !== NS1 || d4 !== NS4) begin
      nmis++; $display("FAIL post_reset_divu: rd %h/%h done@%0d/%0d expected 0000000e %0d/%0d",
                       r1, r4, d1, d4, NS1, NS4);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_kill();
    test_ext_stall();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
`default_nettype wire
